// File: rtl/register_scoreboard.sv
// rtl/register_scoreboard.sv - per-register pending-write scoreboard with issue stall logic
// Optional macro SCOREBOARD_WB_BYPASS_EN: same-cycle writeback makes a source ready.
module register_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          rs1Addr,
  input  logic [4:0]          rs2Addr,
  input  logic                rs1Used,
  input  logic                rs2Used,
  input  logic                issueValid,
  input  logic                issueWEnable,
  input  logic [4:0]          issueRdAddr,
  output logic                issueAccept,
  input  logic                wbValid,
  input  logic [4:0]          wbRdAddr,
  input  logic                flush,
  output logic                rs1Ready,
  output logic                rs2Ready,
  output logic                stall,
  output logic [NUM_REGS-1:0] busyVector
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [CNT_W-1:0]    rs1_cnt;
  logic [CNT_W-1:0]    rs2_cnt;
  logic [CNT_W-1:0]    rd_cnt;
  logic [CNT_W-1:0]    wb_cnt;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic                rs1_byp;
  logic                rs2_byp;
  logic                rd_full;

  // Register 0 is never selected, so its lookups always read as idle.
  always_comb begin
    rs1_cnt = '0;
    rs2_cnt = '0;
    rd_cnt  = '0;
    wb_cnt  = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (rs1Addr == 5'(r))     rs1_cnt = cnt[r];
      if (rs2Addr == 5'(r))     rs2_cnt = cnt[r];
      if (issueRdAddr == 5'(r)) rd_cnt  = cnt[r];
      if (wbRdAddr == 5'(r))    wb_cnt  = cnt[r];
    end
  end

`ifdef SCOREBOARD_WB_BYPASS_EN
  assign rs1_byp = wbValid && (wbRdAddr == rs1Addr) && (rs1_cnt == CNT_ONE);
  assign rs2_byp = wbValid && (wbRdAddr == rs2Addr) && (rs2_cnt == CNT_ONE);
`else
  assign rs1_byp = 1'b0;
  assign rs2_byp = 1'b0;
`endif

  assign rs1Ready = !rs1Used || (rs1Addr == 5'd0) || (rs1_cnt == '0) || rs1_byp;
  assign rs2Ready = !rs2Used || (rs2Addr == 5'd0) || (rs2_cnt == '0) || rs2_byp;
  assign rd_full  = issueWEnable && (issueRdAddr != 5'd0) && (rd_cnt == CNT_MAX);

  assign stall       = issueValid && (!rs1Ready || !rs2Ready || rd_full);
  assign issueAccept = issueValid && !stall && !flush;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      inc_vec[r] = issueAccept && issueWEnable && (issueRdAddr == 5'(r));
      dec_vec[r] = wbValid && (wbRdAddr == 5'(r)) && (cnt[r] != '0);
    end
  end

  // cnt[0] is only ever written by reset/flush, so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else if (flush) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r])
          cnt[r] <= cnt[r] + CNT_ONE;
        else if (dec_vec[r] && !inc_vec[r])
          cnt[r] <= cnt[r] - CNT_ONE;
      end
    end
  end

  always_comb begin
    busyVector = '0;
    for (int r = 0; r < NUM_REGS; r++) busyVector[r] = (cnt[r] != '0);
  end

`ifndef SYNTHESIS
  wb_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(wbValid && (wbRdAddr != 5'd0) && (wb_cnt == '0)));
`endif

endmodule

// File: tb/tb_register_scoreboard.sv
// tb/tb_register_scoreboard.sv - directed and randomized checks of register_scoreboard
module tb_register_scoreboard;

  localparam int MAXC = 3;
`ifdef SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [4:0]  rs1Addr, rs2Addr, issueRdAddr, wbRdAddr;
  logic        rs1Used, rs2Used, issueValid, issueWEnable, wbValid, flush;
  logic        issueAccept, rs1Ready, rs2Ready, stall;
  logic [31:0] busyVector;

  int n_checks = 0;
  int n_fail   = 0;
  int cnt_m [32];

  register_scoreboard #(.NUM_REGS(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
    .rs1Used(rs1Used), .rs2Used(rs2Used), .issueValid(issueValid),
    .issueWEnable(issueWEnable), .issueRdAddr(issueRdAddr),
    .issueAccept(issueAccept), .wbValid(wbValid), .wbRdAddr(wbRdAddr),
    .flush(flush), .rs1Ready(rs1Ready), .rs2Ready(rs2Ready),
    .stall(stall), .busyVector(busyVector)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready(input bit used, input int a);
    return !used || a == 0 || cnt_m[a] == 0 ||
           (BYP && wbValid && int'(wbRdAddr) == a && cnt_m[a] == 1);
  endfunction

  function automatic bit m_stall();
    return issueValid && (!m_ready(rs1Used, int'(rs1Addr)) || !m_ready(rs2Used, int'(rs2Addr)) ||
           (issueWEnable && issueRdAddr != 0 && cnt_m[issueRdAddr] == MAXC));
  endfunction

  function automatic bit m_accept();
    return issueValid && !m_stall() && !flush;
  endfunction

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (cnt_m[r] != 0);
    return b;
  endfunction

  task automatic idle();
    rs1Addr = 0; rs2Addr = 0; rs1Used = 0; rs2Used = 0;
    issueValid = 0; issueWEnable = 0; issueRdAddr = 0;
    wbValid = 0; wbRdAddr = 0; flush = 0;
  endtask

  // Called at posedge+1; checks combinational outputs mid-cycle against the model.
  task automatic settle();
    #3;
    chk("rs1Ready", 32'(rs1Ready), 32'(m_ready(rs1Used, int'(rs1Addr))));
    chk("rs2Ready", 32'(rs2Ready), 32'(m_ready(rs2Used, int'(rs2Addr))));
    chk("stall", 32'(stall), 32'(m_stall()));
    chk("issueAccept", 32'(issueAccept), 32'(m_accept()));
    chk("busyVector", busyVector, m_busy());
  endtask

  task automatic tick();
    bit acc, inc, dec;
    acc = m_accept();
    @(posedge clk);
    if (!rst || flush) begin
      for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    end else begin
      inc = acc && issueWEnable && issueRdAddr != 0;
      dec = wbValid && wbRdAddr != 0 && cnt_m[wbRdAddr] > 0;
      if (!(inc && dec && issueRdAddr == wbRdAddr)) begin
        if (inc) cnt_m[issueRdAddr]++;
        if (dec) cnt_m[wbRdAddr]--;
      end
    end
    #1;
  endtask

  task automatic issue_rd(input int rd);
    idle(); issueValid = 1; issueWEnable = 1; issueRdAddr = 5'(rd);
    settle(); tick();
  endtask

  initial begin
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    rst = 0;
    idle();
    @(posedge clk); #1;

    // Reset state
    rs1Addr = 5; rs1Used = 1;
    settle();
    chk("rst_ready1", 32'(rs1Ready), 32'd1);
    chk("rst_busy", busyVector, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    tick();
    rst = 1;

    // Reset released, source x5 idle
    settle();
    chk("idle_ready1", 32'(rs1Ready), 32'd1);
    tick();

    // Issue x5 then a reader of x5
    issue_rd(5);
    idle(); issueValid = 1; rs1Addr = 5; rs1Used = 1;
    settle();
    chk("raw_stall", 32'(stall), 32'd1);
    chk("raw_accept", 32'(issueAccept), 32'd0);
    chk("raw_busy5", 32'(busyVector[5]), 32'd1);
    tick();

    // Writeback of x5 while reading x5
    wbValid = 1; wbRdAddr = 5;
    settle();
    chk("wb_bypass_stall", 32'(stall), BYP ? 32'd0 : 32'd1);
    tick();
    wbValid = 0;
    settle();
    chk("after_wb_stall", 32'(stall), 32'd0);
    tick();

    // Saturate x7
    issue_rd(7); issue_rd(7); issue_rd(7);
    idle(); issueValid = 1; issueWEnable = 1; issueRdAddr = 7;
    settle();
    chk("full_stall", 32'(stall), 32'd1);
    wbValid = 1; wbRdAddr = 7;
    settle();
    chk("full_wb_stall", 32'(stall), 32'd1);
    tick();
    settle();
    chk("cnt2_issue_wb_accept", 32'(issueAccept), 32'd1);
    tick();
    wbValid = 0;
    settle();
    chk("cnt2_held_accept", 32'(issueAccept), 32'd1);
    tick();
    settle();
    chk("cnt3_stall", 32'(stall), 32'd1);
    idle(); wbValid = 1; wbRdAddr = 7;
    for (int i = 0; i < 3; i++) begin settle(); tick(); end
    idle(); settle();
    chk("x7_drained", 32'(busyVector[7]), 32'd0);
    tick();

    // Register 0 never tracked
    idle(); issueValid = 1; issueWEnable = 1; issueRdAddr = 0; rs2Addr = 0; rs2Used = 1;
    settle();
    chk("x0_ready2", 32'(rs2Ready), 32'd1);
    chk("x0_accept", 32'(issueAccept), 32'd1);
    tick();
    settle();
    chk("x0_busy", 32'(busyVector[0]), 32'd0);
    tick();

    // Flush overrides issue
    issue_rd(3); issue_rd(9);
    idle(); flush = 1; issueValid = 1; issueWEnable = 1; issueRdAddr = 11;
    settle();
    chk("flush_accept", 32'(issueAccept), 32'd0);
    tick();
    idle(); settle();
    chk("flush_busy", busyVector, 32'd0);
    tick();

    // Asynchronous reset mid-stall
    issue_rd(4);
    idle(); issueValid = 1; rs1Addr = 4; rs1Used = 1;
    settle();
    chk("pre_rst_stall", 32'(stall), 32'd1);
    rst = 0;
    #1;
    chk("async_rst_stall", 32'(stall), 32'd0);
    chk("async_rst_busy", busyVector, 32'd0);
    for (int r = 0; r < 32; r++) cnt_m[r] = 0;
    @(posedge clk); #1;
    rst = 1;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      int a;
      idle();
      rs1Addr      = 5'($urandom_range(0, 15));
      rs2Addr      = 5'($urandom_range(0, 15));
      rs1Used      = 1'($urandom_range(0, 1));
      rs2Used      = 1'($urandom_range(0, 1));
      issueValid   = 1'($urandom_range(0, 1));
      issueWEnable = 1'($urandom_range(0, 1));
      issueRdAddr  = 5'($urandom_range(0, 15));
      a = $urandom_range(0, 15);
      wbRdAddr = 5'(a);
      wbValid  = ($urandom_range(0, 3) != 0) && (a == 0 || cnt_m[a] > 0);
      flush    = ($urandom_range(0, 31) == 0);
      settle();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
